pooling_max_unit: RTL and testbench

- Downstream neighbour of the pooling input serializer.
- Consumes the serialized stream of IEEE-754 single-precision words, one per cycle when valid.
- Reduces each group of KERNEL_SIZE*KERNEL_SIZE consecutive valid words to their maximum.
- Emits the pooled word with a one-cycle valid pulse toward the pooling output buffer.

---
 rtl/pooling_max_unit_pkg.sv | 25 ++
 rtl/pooling_max_unit_fp_max_cmp.sv | 36 +++
 rtl/pooling_max_unit.sv | 89 ++++++++
 tb/tb_pooling_max_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pooling_max_unit_pkg.sv
// Shared pooling parameters, FSM state encoding and IEEE-754 single-precision field layout.
package pooling_max_unit_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned KERNEL_SIZE = 2;
  localparam int unsigned WINDOW      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned CNT_W       = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned MAG_W    = EXP_W + MANT_W;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/pooling_max_unit_fp_max_cmp.sv
// Combinational sign-magnitude maximum of two single-precision words; ties keep operand a.
module fp_max_cmp
  import pooling_max_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] max,
  output logic                  a_ge_b
);

  fp32_t            fa;
  fp32_t            fb;
  logic [MAG_W-1:0] mag_a;
  logic [MAG_W-1:0] mag_b;

  assign fa    = fp32_t'(a);
  assign fb    = fp32_t'(b);
  assign mag_a = {fa.exp, fa.mant};
  assign mag_b = {fb.exp, fb.mant};

  // Exponent 0xFF is an ordinary magnitude here: NaN/inf are ordered by bit pattern.
  always_comb begin
    a_ge_b = 1'b1;
    if ((mag_a == '0) && (mag_b == '0)) begin
      a_ge_b = 1'b1;
    end else if (fa.sign != fb.sign) begin
      a_ge_b = ~fa.sign;
    end else if (!fa.sign) begin
      a_ge_b = (mag_a >= mag_b);
    end else begin
      a_ge_b = (mag_a <= mag_b);
    end
    max = a_ge_b ? a : b;
  end

endmodule

// File: rtl/pooling_max_unit.sv
// Max-pools each window of WINDOW consecutive valid float words into one registered result pulse.
module pooling_max_unit
  import pooling_max_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] cmp_max;
  logic                  cmp_a_ge_b;

  fp_max_cmp u_cmp (
    .a      (acc_q),
    .b      (data_in),
    .max    (cmp_max),
    .a_ge_b (cmp_a_ge_b)
  );

  // Next-state: clear beats in_valid; the last element of a window lands straight in data_out.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (WINDOW == 1) begin
            data_out_d  = data_in;
            out_valid_d = 1'b1;
          end else begin
            acc_d   = data_in;
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          acc_d = cmp_max;
          if (cnt_q == CNT_W'(WINDOW - 1)) begin
            data_out_d  = cmp_a_ge_b ? acc_q : data_in;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_pooling_max_unit.sv
// Directed and randomized bench for pooling_max_unit against a rank-based window-max model.
module tb_pooling_max_unit;
  import pooling_max_unit_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  clear;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;

  int n_checks;
  int n_fail;

  // Model state: running best of the open window plus how many words it holds.
  int                    m_count;
  logic [DATA_WIDTH-1:0] m_best;
  logic                  m_ov;
  logic [DATA_WIDTH-1:0] m_do;

  pooling_max_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .clear     (clear),
    .out_valid (out_valid),
    .data_out  (data_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Total order on floats by bit pattern: +x ranks by magnitude, -x by negated magnitude.
  function automatic longint rank(input logic [31:0] w);
    longint mag;
    mag = longint'(w[30:0]);
    return w[31] ? -mag : mag;
  endfunction

  initial begin
    m_count = 0;
    m_best  = '0;
    m_ov    = 1'b0;
    m_do    = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_count = 0;
        m_best  = '0;
        m_ov    = 1'b0;
        m_do    = '0;
      end else begin
        m_ov = 1'b0;
        if (clear) begin
          m_count = 0;
        end else if (in_valid) begin
          if (m_count == 0 || rank(data_in) > rank(m_best)) m_best = data_in;
          m_count++;
          if (m_count == int'(WINDOW)) begin
            m_do    = m_best;
            m_ov    = 1'b1;
            m_count = 0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("data_out", data_out, m_do);
    check("busy", 32'(busy), 32'(m_count != 0));
  endtask

  // Drive one cycle's inputs just after a negedge, then compare at the following negedge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic c);
    in_valid = v;
    data_in  = d;
    clear    = c;
    @(negedge clk);
    compare_all();
  endtask

  task automatic feed4(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    cycle(1'b1, w0, 1'b0);
    cycle(1'b1, w1, 1'b0);
    cycle(1'b1, w2, 1'b0);
    cycle(1'b1, w3, 1'b0);
  endtask

  function automatic logic [31:0] pick_word();
    logic [31:0] pool [8];
    pool[0] = 32'h0000_0000; pool[1] = 32'h8000_0000;
    pool[2] = 32'h7F80_0000; pool[3] = 32'h7FC0_0000;
    pool[4] = 32'hFF80_0000; pool[5] = 32'h0000_0001;
    pool[6] = 32'h3F80_0000; pool[7] = 32'hBF80_0000;
    if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    clear    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_data_out", data_out, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // 1, 2, 0.5, 3 -> 3.0 one cycle after the last word
    cycle(1'b1, 32'h3F80_0000, 1'b0);
    check("busy_c1", 32'(busy), 32'h1);
    cycle(1'b1, 32'h4000_0000, 1'b0);
    check("busy_c2", 32'(busy), 32'h1);
    cycle(1'b1, 32'h3F00_0000, 1'b0);
    check("busy_c3", 32'(busy), 32'h1);
    cycle(1'b1, 32'h4040_0000, 1'b0);
    check("win1_valid", 32'(out_valid), 32'h1);
    check("win1_data", data_out, 32'h4040_0000);
    check("model_pin_win1", m_do, 32'h4040_0000);
    check("win1_busy", 32'(busy), 32'h0);
    cycle(1'b0, 32'h0, 1'b0);
    check("win1_pulse_end", 32'(out_valid), 32'h0);

    feed4(32'hBF80_0000, 32'hC040_0000, 32'hBF00_0000, 32'hC000_0000);
    check("neg_data", data_out, 32'hBF00_0000);
    check("model_pin_neg", m_do, 32'hBF00_0000);
    feed4(32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'h8000_0000);
    check("zero_tie_data", data_out, 32'h8000_0000);
    check("model_pin_zero", m_do, 32'h8000_0000);

    // Gap of three idle cycles inside a window
    cycle(1'b1, 32'h3F80_0000, 1'b0);
    cycle(1'b1, 32'h4000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'hDEAD_BEEF, 1'b0);
      check("gap_no_valid", 32'(out_valid), 32'h0);
    end
    cycle(1'b1, 32'h3F00_0000, 1'b0);
    cycle(1'b1, 32'h4040_0000, 1'b0);
    check("gap_valid", 32'(out_valid), 32'h1);
    check("gap_data", data_out, 32'h4040_0000);

    // Back-to-back windows
    feed4(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4040_0000);
    check("b2b_first", data_out, 32'h4040_0000);
    feed4(32'hBF80_0000, 32'hC040_0000, 32'hBF00_0000, 32'hC000_0000);
    check("b2b_second_valid", 32'(out_valid), 32'h1);
    check("b2b_second", data_out, 32'hBF00_0000);

    // Clear aborts a partial window, even with in_valid set
    cycle(1'b1, 32'h40A0_0000, 1'b0);
    cycle(1'b1, 32'h40C0_0000, 1'b0);
    cycle(1'b1, 32'h40E0_0000, 1'b0);
    cycle(1'b1, 32'h4100_0000, 1'b1);
    check("clear_no_valid", 32'(out_valid), 32'h0);
    check("clear_data_held", data_out, 32'hBF00_0000);
    check("clear_busy", 32'(busy), 32'h0);
    feed4(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000);
    check("post_clear_valid", 32'(out_valid), 32'h1);
    check("post_clear_data", data_out, 32'h3F00_0000);

    // Asynchronous reset mid-window
    cycle(1'b1, 32'h4120_0000, 1'b0);
    cycle(1'b1, 32'h4130_0000, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_data", data_out, 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    feed4(32'h3E80_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h3F40_0000);
    check("post_rst_valid", 32'(out_valid), 32'h1);
    check("post_rst_data", data_out, 32'h3F40_0000);

    // Randomized traffic with gaps, clears and special values
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 7), pick_word(), ($urandom_range(0, 39) == 0));
    end
    cycle(1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
